// File: rtl/ss_mux_driver.sv
// Multiplexed seven-segment display driver: scans DIGITS digits, captures inputs once per
// frame into shadow registers, and applies anti-ghost, PWM, blink and leading-zero blanking.
module ss_mux_driver #(
    parameter int DIGITS    = 4,
    parameter int DIV_BITS  = 17,
    parameter int PWM_BITS  = 8,
    parameter int BLANK_CYC = 16,
    parameter int BLINK_BIT = 8
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [4*DIGITS-1:0]   Digits,
    input  logic [DIGITS-1:0]     DP,
    input  logic [DIGITS-1:0]     Blink,
    input  logic                  BlankZero,
    input  logic [PWM_BITS-1:0]   Brightness,
    output logic [DIGITS-1:0]     SegmentDrivers,
    output logic [7:0]            SevenSegment,
    output logic                  Snapshot
);

    localparam int IDX_W = $clog2(DIGITS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [DIV_BITS-1:0]  r_count;
    logic [IDX_W-1:0]     r_idx;
    logic [PWM_BITS-1:0]  r_pwm;
    logic [BLINK_BIT:0]   r_frame;
    logic [4*DIGITS-1:0]  r_sh_digits;
    logic [DIGITS-1:0]    r_sh_dp;
    logic [DIGITS-1:0]    r_sh_blink;
    logic                 r_sh_bz;
    logic [PWM_BITS-1:0]  r_sh_bright;
    logic [DIGITS-1:0]    r_seg_drv;
    logic [7:0]           r_seven;
    logic                 r_snap;

    logic                 w_tick;
    logic                 w_wrap;
    logic                 w_ghost;
    logic                 w_blank;
    logic [3:0]           w_nib;
    logic                 w_dp;
    logic                 w_blink;
    logic                 w_lz;
    logic                 w_zero_run;

    assign w_tick = &r_count;
    assign w_wrap = w_tick && (r_idx == IDX_LAST);

    generate
        if (BLANK_CYC == 0) begin : g_no_ghost
            assign w_ghost = 1'b0;
        end else begin : g_ghost
            localparam logic [DIV_BITS-1:0] BLANK_V = DIV_BITS'(BLANK_CYC);
            assign w_ghost = (r_count < BLANK_V);
        end
    endgenerate

    function automatic logic [6:0] f_glyph(input logic [3:0] nib);
        case (nib)
            4'h0: f_glyph = 7'b1000000;
            4'h1: f_glyph = 7'b1111001;
            4'h2: f_glyph = 7'b0100100;
            4'h3: f_glyph = 7'b0110000;
            4'h4: f_glyph = 7'b0011001;
            4'h5: f_glyph = 7'b0010010;
            4'h6: f_glyph = 7'b0000010;
            4'h7: f_glyph = 7'b1111000;
            4'h8: f_glyph = 7'b0000000;
            4'h9: f_glyph = 7'b0010000;
            4'hA: f_glyph = 7'b0001000;
            4'hB: f_glyph = 7'b0000011;
            4'hC: f_glyph = 7'b1000110;
            4'hD: f_glyph = 7'b0100001;
            4'hE: f_glyph = 7'b0000110;
            default: f_glyph = 7'b0001110;
        endcase
    endfunction

    // Walk from the most significant digit down so the zero run covers all nibbles j >= i.
    always_comb begin
        w_nib      = 4'h0;
        w_dp       = 1'b0;
        w_blink    = 1'b0;
        w_lz       = 1'b0;
        w_zero_run = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_zero_run = w_zero_run && (r_sh_digits[4*i +: 4] == 4'h0);
            if (r_idx == IDX_W'(i)) begin
                w_nib   = r_sh_digits[4*i +: 4];
                w_dp    = r_sh_dp[i];
                w_blink = r_sh_blink[i];
                w_lz    = (i != 0) && w_zero_run;
            end
        end
    end

    assign w_blank = w_ghost
                  || !(r_pwm < r_sh_bright)
                  || (w_blink && r_frame[BLINK_BIT])
                  || (r_sh_bz && w_lz);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_count     <= '0;
            r_idx       <= '0;
            r_pwm       <= '0;
            r_frame     <= '0;
            r_sh_digits <= '0;
            r_sh_dp     <= '0;
            r_sh_blink  <= '0;
            r_sh_bz     <= 1'b0;
            r_sh_bright <= '0;
            r_seg_drv   <= {{(DIGITS-1){1'b1}}, 1'b0};
            r_seven     <= 8'hFF;
            r_snap      <= 1'b0;
        end else begin
            r_count <= r_count + 1'b1;
            r_pwm   <= r_pwm + 1'b1;
            if (w_tick) begin
                r_idx <= w_wrap ? '0 : r_idx + 1'b1;
            end
            if (w_wrap) begin
                r_sh_digits <= Digits;
                r_sh_dp     <= DP;
                r_sh_blink  <= Blink;
                r_sh_bz     <= BlankZero;
                r_sh_bright <= Brightness;
                r_frame     <= r_frame + 1'b1;
            end
            r_seg_drv <= ~(DIGITS'(1) << r_idx);
            r_seven   <= w_blank ? 8'hFF : {~w_dp, f_glyph(w_nib)};
            r_snap    <= w_wrap;
        end
    end

    assign SegmentDrivers = r_seg_drv;
    assign SevenSegment   = r_seven;
    assign Snapshot       = r_snap;

endmodule

// File: tb/tb_ss_mux_driver.sv
// Scoreboard bench: stimulus pushes the expected per-slot picture for every frame it
// schedules; one monitor per DUT summarises each digit slot and compares against the queue.
module tb_ss_mux_driver;

    typedef struct {
        logic [15:0] dig;
        logic [3:0]  dp;
        logic [3:0]  blink;
        logic        bz;
        logic [7:0]  br;
    } vec_t;

    typedef struct {
        logic [3:0] sd;
        logic [7:0] glyph;
        int         lit;
        int         snaps;
        int         frame;
        int         digit;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] digits = '0;
    logic [3:0]  dp = '0;
    logic [3:0]  blink = '0;
    logic        bz = 1'b0;
    logic [7:0]  bright = '0;
    logic [3:0]  sd_a, sd_b;
    logic [7:0]  ss_a, ss_b;
    logic        snap_a, snap_b;

    exp_t qa[$];
    exp_t qb[$];
    vec_t vecs[13];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    ss_mux_driver #(.DIGITS(4), .DIV_BITS(3), .PWM_BITS(8), .BLANK_CYC(0), .BLINK_BIT(1)) dut_a (
        .Clk(clk), .Reset(rst_n), .Digits(digits), .DP(dp), .Blink(blink), .BlankZero(bz),
        .Brightness(bright), .SegmentDrivers(sd_a), .SevenSegment(ss_a), .Snapshot(snap_a));

    ss_mux_driver #(.DIGITS(4), .DIV_BITS(3), .PWM_BITS(8), .BLANK_CYC(2), .BLINK_BIT(1)) dut_b (
        .Clk(clk), .Reset(rst_n), .Digits(digits), .DP(dp), .Blink(blink), .BlankZero(bz),
        .Brightness(bright), .SegmentDrivers(sd_b), .SevenSegment(ss_b), .Snapshot(snap_b));

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'h40; 4'h1: seg7 = 7'h79; 4'h2: seg7 = 7'h24; 4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19; 4'h5: seg7 = 7'h12; 4'h6: seg7 = 7'h02; 4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00; 4'h9: seg7 = 7'h10; 4'hA: seg7 = 7'h08; 4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46; 4'hD: seg7 = 7'h21; 4'hE: seg7 = 7'h06; default: seg7 = 7'h0E;
        endcase
    endfunction

    task automatic check(input string name, input int fr, input int dg, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s (frame %0d digit %0d): got %0h expected %0h", name, fr, dg, act, exp);
        end
    endtask

    // Expected picture of frame f (counted from reset release) showing vector v.
    task automatic push_frame(input int f, input vec_t v);
        for (int d = 0; d < 4; d++) begin
            for (int id = 0; id < 2; id++) begin
                exp_t e;
                int   k, bc, lit;
                logic blanked;
                logic [15:0] upper;
                logic [3:0]  nib;
                k     = 4 * f + d;
                bc    = (id == 0) ? 0 : 2;
                upper = v.dig >> (4 * d);
                nib   = upper[3:0];
                blanked = (v.blink[d] && (((f >> 1) & 1) == 1)) || (v.bz && d >= 1 && upper == 16'h0);
                lit = 0;
                if (!blanked)
                    for (int c = bc; c < 8; c++)
                        if (((8 * k + c) % 256) < int'(v.br)) lit++;
                e.sd    = ~(4'b0001 << d);
                e.glyph = (lit > 0) ? {~v.dp[d], seg7(nib)} : 8'hFF;
                e.lit   = lit;
                e.snaps = (d == 3) ? 1 : 0;
                e.frame = f;
                e.digit = d;
                if (id == 0) qa.push_back(e); else qb.push_back(e);
            end
        end
    endtask

    task automatic apply(input vec_t v);
        digits = v.dig; dp = v.dp; blink = v.blink; bz = v.bz; bright = v.br;
    endtask

    task automatic monitor(input int id);
        logic [3:0] sd, prev_sd;
        logic [7:0] ss, acc;
        logic       sn;
        int         n, lit, snaps;
        exp_t       e;
        string      pfx;
        pfx = (id == 0) ? "dutA" : "dutB";
        n = 0; acc = 8'hFF; lit = 0; snaps = 0; prev_sd = '0;
        forever begin
            @(negedge clk);
            sd = (id == 0) ? sd_a : sd_b;
            ss = (id == 0) ? ss_a : ss_b;
            sn = (id == 0) ? snap_a : snap_b;
            if (!rst_n) begin
                n = 0;
                continue;
            end
            if (n > 0 && sd != prev_sd) begin
                if ((id == 0 && qa.size() == 0) || (id == 1 && qb.size() == 0)) begin
                    check({pfx, " unexpected slot"}, -1, -1, int'(prev_sd), -1);
                end else begin
                    e = (id == 0) ? qa.pop_front() : qb.pop_front();
                    check({pfx, " digit enable"}, e.frame, e.digit, int'(prev_sd), int'(e.sd));
                    check({pfx, " glyph"}, e.frame, e.digit, int'(acc), int'(e.glyph));
                    check({pfx, " lit cycles"}, e.frame, e.digit, lit, e.lit);
                    check({pfx, " snapshot pulses"}, e.frame, e.digit, snaps, e.snaps);
                    check({pfx, " slot length"}, e.frame, e.digit, n, 8);
                end
                n = 0;
            end
            if (n == 0) begin
                acc = 8'hFF; lit = 0; snaps = 0;
            end
            acc = acc & ss;
            if (ss != 8'hFF) lit++;
            if (sn) snaps++;
            n++;
            prev_sd = sd;
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    task automatic wait_snap();
        logic seen;
        seen = 1'b0;
        for (int t = 0; t < 64 && !seen; t++) begin
            @(negedge clk);
            if (snap_a && snap_b) seen = 1'b1;
        end
        check("snapshot arrival", -1, -1, int'(seen), 1);
    endtask

    initial begin
        vec_t zero_v;
        logic drained;
        zero_v    = '{16'h0000, 4'h0, 4'h0, 1'b0, 8'h00};
        vecs[0]   = zero_v;
        vecs[1]   = '{16'h1234, 4'h0, 4'h0, 1'b0, 8'hFF};
        vecs[2]   = '{16'h0050, 4'h0, 4'h0, 1'b1, 8'hFF};
        vecs[3]   = '{16'h0050, 4'h0, 4'h0, 1'b0, 8'hFF};
        vecs[4]   = '{16'h8888, 4'h0, 4'h0, 1'b0, 8'h00};
        vecs[5]   = '{16'hABCD, 4'h8, 4'h0, 1'b1, 8'hFF};
        vecs[6]   = '{16'h1234, 4'h4, 4'h1, 1'b0, 8'hFF};
        vecs[7]   = '{16'h1234, 4'h4, 4'h1, 1'b0, 8'hFF};
        vecs[8]   = '{16'h8888, 4'h0, 4'h1, 1'b0, 8'h40};
        vecs[9]   = '{16'h1234, 4'h4, 4'h1, 1'b0, 8'h40};
        vecs[10]  = '{16'h0000, 4'h2, 4'h0, 1'b1, 8'h41};
        vecs[11]  = '{16'h1234, 4'hF, 4'h0, 1'b0, 8'hFF};
        vecs[12]  = '{16'h5678, 4'h1, 4'h0, 1'b0, 8'hFF};

        repeat (4) @(negedge clk);
        #1 rst_n = 1'b1;
        push_frame(0, zero_v);
        apply(vecs[1]);
        push_frame(1, vecs[1]);
        for (int i = 2; i <= 11; i++) begin
            wait_snap();
            repeat (12) @(negedge clk);
            #1 apply(vecs[i]);
            push_frame(i, vecs[i]);
        end
        wait_snap();

        // Reset in the middle of frame 11 while digit 2 is lit.
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        qa.delete();
        qb.delete();
        #1;
        check("dutA reset digit enable", 11, 2, int'(sd_a), 4'hE);
        check("dutA reset segments", 11, 2, int'(ss_a), 8'hFF);
        check("dutA reset snapshot", 11, 2, int'(snap_a), 0);
        check("dutB reset digit enable", 11, 2, int'(sd_b), 4'hE);
        check("dutB reset segments", 11, 2, int'(ss_b), 8'hFF);
        check("dutB reset snapshot", 11, 2, int'(snap_b), 0);

        repeat (5) @(negedge clk);
        #1 rst_n = 1'b1;
        push_frame(0, zero_v);
        apply(vecs[12]);
        push_frame(1, vecs[12]);

        drained = 1'b0;
        for (int t = 0; t < 200 && !drained; t++) begin
            @(negedge clk);
            if (qa.size() == 0 && qb.size() == 0) drained = 1'b1;
        end
        check("scoreboard drained", -1, -1, int'(drained), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
